// File: rtl/usb_pkg.sv
// usb_pkg: PID constants, packet widths and enums shared by the USB protocol engine.
package usb_pkg;

    localparam int TOKEN_W   = 19;
    localparam int PKT_W     = 72;
    localparam int PAYLOAD_W = 64;

    localparam logic [7:0] PID_OUT  = 8'b10000111;
    localparam logic [7:0] PID_IN   = 8'b10010110;
    localparam logic [7:0] PID_DATA = 8'b11000011;
    localparam logic [7:0] PID_ACK  = 8'b01001011;
    localparam logic [7:0] PID_NAK  = 8'b01011010;

    typedef enum logic [1:0] {
        TK_TOKEN = 2'b00,
        TK_DATA  = 2'b01,
        TK_HS    = 2'b10
    } tx_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_TOK,
        ST_SEND_DATA,
        ST_WAIT_HS,
        ST_WAIT_DATA,
        ST_SEND_HS,
        ST_DONE
    } ptcl_state_t;

endpackage

// File: rtl/ptcl_timer.sv
// ptcl_timer: wait-state timeout counter; expire is high on the last allowed wait cycle.
module ptcl_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire = en && cnt_q == W'(TIMEOUT_CYC - 1);

endmodule

// File: rtl/usb_protocol_fsm.sv
// usb_protocol_fsm: host-side USB transaction engine (token/data/handshake, timeouts, retries).
// Optional USB_PTCL_STATS_EN adds a saturating err_count of failed attempts.
module usb_protocol_fsm
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYC  = 255,
    parameter int MAX_ATTEMPTS = 8
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 data_avail,
    input  logic [TOKEN_W-1:0]   token_pkt,
    input  logic [PKT_W-1:0]     data_pkt,
    output logic                 ptcl_ready,
    output logic                 ptcl_done,
    output logic                 ptcl_success,
    output logic [PAYLOAD_W-1:0] ptcl_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [1:0]           tx_kind,
    output logic [PKT_W-1:0]     tx_pkt,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_pid,
    input  logic [PAYLOAD_W-1:0] rx_data,
`ifdef USB_PTCL_STATS_EN
    output logic [15:0]          err_count,
`endif
    input  logic                 rx_crc_ok
);

    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    ptcl_state_t          state_q, state_d;
    logic [AW-1:0]        attempt_q, attempt_d;
    logic [TOKEN_W-1:0]   tok_q, tok_d;
    logic [PKT_W-1:0]     dat_q, dat_d;
    logic [7:0]           hs_q, hs_d;
    logic                 success_q, success_d;
    logic [PAYLOAD_W-1:0] data_q, data_d;
    logic                 in_wait, expire, fail, rx_good;
    tx_kind_t             kind;

    assign in_wait = state_q == ST_WAIT_HS || state_q == ST_WAIT_DATA;
    assign rx_good = rx_pid == PID_DATA && rx_crc_ok;

    ptcl_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (!in_wait),
        .en     (in_wait),
        .expire (expire)
    );

    always_comb begin
        state_d   = state_q;
        attempt_d = attempt_q;
        tok_d     = tok_q;
        dat_d     = dat_q;
        hs_d      = hs_q;
        success_d = success_q;
        data_d    = data_q;
        fail      = 1'b0;
        unique case (state_q)
            ST_IDLE: if (data_avail) begin
                tok_d     = token_pkt;
                dat_d     = data_pkt;
                attempt_d = '0;
                success_d = 1'b0;
                state_d   = ST_SEND_TOK;
            end
            ST_SEND_TOK:  if (tx_ready) state_d = tok_q[18:11] == PID_IN ? ST_WAIT_DATA : ST_SEND_DATA;
            ST_SEND_DATA: if (tx_ready) state_d = ST_WAIT_HS;
            ST_WAIT_HS: begin
                if (rx_valid && rx_pid == PID_ACK) begin
                    state_d   = ST_DONE;
                    success_d = 1'b1;
                end else fail = rx_valid || expire;
            end
            ST_WAIT_DATA: begin
                if (rx_valid) begin
                    hs_d    = rx_good ? PID_ACK : PID_NAK;
                    data_d  = rx_good ? rx_data : data_q;
                    state_d = ST_SEND_HS;
                end else fail = expire;
            end
            ST_SEND_HS: begin
                if (tx_ready && hs_q == PID_ACK) begin
                    state_d   = ST_DONE;
                    success_d = 1'b1;
                end else fail = tx_ready;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Every failure path funnels here so retry accounting lives in one place.
        if (fail) begin
            state_d   = attempt_q == AW'(MAX_ATTEMPTS - 1) ? ST_DONE : ST_SEND_TOK;
            attempt_d = attempt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            attempt_q <= '0;
            tok_q     <= '0;
            dat_q     <= '0;
            hs_q      <= '0;
            success_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            attempt_q <= attempt_d;
            tok_q     <= tok_d;
            dat_q     <= dat_d;
            hs_q      <= hs_d;
            success_q <= success_d;
            data_q    <= data_d;
        end
    end

`ifdef USB_PTCL_STATS_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb err_count_d = (fail && err_count_q != '1) ? err_count_q + 1'b1 : err_count_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) err_count_q <= '0;
        else        err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif

    always_comb begin
        kind   = state_q == ST_SEND_DATA ? TK_DATA : state_q == ST_SEND_HS ? TK_HS : TK_TOKEN;
        tx_pkt = state_q == ST_SEND_DATA ? dat_q :
                 state_q == ST_SEND_HS   ? {{(PKT_W-8){1'b0}}, hs_q} :
                 state_q == ST_SEND_TOK  ? {{(PKT_W-TOKEN_W){1'b0}}, tok_q} : '0;
    end

    assign tx_kind      = kind;
    assign tx_valid     = state_q == ST_SEND_TOK || state_q == ST_SEND_DATA || state_q == ST_SEND_HS;
    assign ptcl_ready   = state_q == ST_IDLE;
    assign ptcl_done    = state_q == ST_DONE;
    assign ptcl_success = ptcl_done && success_q;
    assign ptcl_data    = data_q;

endmodule

// File: tb/tb_usb_protocol_fsm.sv
// tb_usb_protocol_fsm: scripted host/encoder/decoder model driving random and directed transactions.
module tb_usb_protocol_fsm;
    import usb_pkg::*;

    localparam int TO   = 16;
    localparam int MAXA = 8;

    logic        clk = 1'b0, rst_b = 1'b0, data_avail = 1'b0, tx_ready = 1'b0;
    logic        rx_valid = 1'b0, rx_crc_ok = 1'b0;
    logic [18:0] token_pkt = '0;
    logic [71:0] data_pkt = '0;
    logic [7:0]  rx_pid = '0;
    logic [63:0] rx_data = '0;
    logic        ptcl_ready, ptcl_done, ptcl_success, tx_valid;
    logic [63:0] ptcl_data;
    logic [1:0]  tx_kind;
    logic [71:0] tx_pkt;
`ifdef USB_PTCL_STATS_EN
    logic [15:0] err_count;
`endif

    int          n_tests = 0, n_fail = 0;
    int          resp[MAXA], dly[MAXA], stall[MAXA];
    logic [63:0] data_exp = '0;
    int          errs_exp = 0;

    usb_protocol_fsm #(.TIMEOUT_CYC(TO), .MAX_ATTEMPTS(MAXA)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .data_avail   (data_avail),
        .token_pkt    (token_pkt),
        .data_pkt     (data_pkt),
        .ptcl_ready   (ptcl_ready),
        .ptcl_done    (ptcl_done),
        .ptcl_success (ptcl_success),
        .ptcl_data    (ptcl_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_kind      (tx_kind),
        .tx_pkt       (tx_pkt),
        .rx_valid     (rx_valid),
        .rx_pid       (rx_pid),
        .rx_data      (rx_data),
`ifdef USB_PTCL_STATS_EN
        .err_count    (err_count),
`endif
        .rx_crc_ok    (rx_crc_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Encoder side: the packet must be offered now and held stable through the stall.
    task automatic offer(input logic [1:0] k, input logic [71:0] p, input int st);
        for (int i = 0; i <= st; i++) begin
            check("tx_valid", tx_valid, 1);
            check("tx_kind", tx_kind, k);
            check("tx_pkt", tx_pkt, p);
            tx_ready   = (i == st);
            rx_valid   = (i < st) && ($urandom % 2 == 1);
            rx_pid     = PID_ACK;
            data_avail = ($urandom % 2 == 1);
            step();
        end
        tx_ready   = 1'b0;
        rx_valid   = 1'b0;
        data_avail = 1'b0;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            check("wait_quiet", {tx_valid, ptcl_done}, 0);
            step();
        end
    endtask

    task automatic plan_all(input int r, input int d, input int s);
        for (int a = 0; a < MAXA; a++) begin
            resp[a]  = r;
            dly[a]   = d;
            stall[a] = s;
        end
    endtask

    // resp: 0 silence, 1 good (ACK / good DATA), 2 NAK / bad CRC, 3 unexpected PID
    task automatic run_txn(input logic is_in, input logic [7:0] pid, input logic [63:0] good_pl);
        logic [18:0] tok;
        logic [71:0] dpk;
        logic        ok;
        int          a;
        tok = {pid, 7'($urandom), 4'($urandom)};
        dpk = {8'($urandom), 32'($urandom), 32'($urandom)};
        check("ready", ptcl_ready, 1);
        token_pkt  = tok;
        data_pkt   = dpk;
        data_avail = 1'b1;
        step();
        data_avail = 1'b0;
        token_pkt  = 19'($urandom);
        data_pkt   = {8'($urandom), 32'($urandom), 32'($urandom)};
        ok = 1'b0;
        a  = 0;
        while (!ok && a < MAXA) begin
            offer(TK_TOKEN, {53'd0, tok}, stall[a]);
            if (!is_in) offer(TK_DATA, dpk, stall[a] % 2);
            if (resp[a] == 0) quiet(TO);
            else begin
                quiet(dly[a]);
                rx_valid  = 1'b1;
                rx_crc_ok = !(is_in && resp[a] == 2);
                rx_pid    = is_in ? (resp[a] == 3 ? PID_ACK : PID_DATA)
                                  : (resp[a] == 1 ? PID_ACK : resp[a] == 2 ? PID_NAK : PID_DATA);
                rx_data   = resp[a] == 1 ? good_pl : {32'($urandom), 32'($urandom)};
                step();
                rx_valid  = 1'b0;
                rx_crc_ok = 1'($urandom);
                rx_pid    = 8'($urandom);
                if (is_in) offer(TK_HS, {64'd0, resp[a] == 1 ? PID_ACK : PID_NAK}, stall[a] % 3);
                ok = (resp[a] == 1);
                if (ok && is_in) data_exp = good_pl;
            end
            if (!ok) errs_exp++;
            a++;
        end
        check("done", ptcl_done, 1);
        check("success", ptcl_success, ok);
        step();
        check("done_pulse", ptcl_done, 0);
        check("ready_after", ptcl_ready, 1);
        check("ptcl_data", ptcl_data, data_exp);
`ifdef USB_PTCL_STATS_EN
        check("err_count", err_count, errs_exp);
`endif
    endtask

    task automatic reset_mid(input logic in_tok);
        token_pkt  = {PID_IN, 7'h11, 4'h3};
        data_avail = 1'b1;
        step();
        data_avail = 1'b0;
        if (in_tok) check("tok_offer", tx_valid, 1);
        else begin
            offer(TK_TOKEN, {53'd0, PID_IN, 7'h11, 4'h3}, 0);
            quiet(3);
        end
        #2 rst_b = 1'b0;
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_ready", ptcl_ready, 1);
        check("rst_done", ptcl_done, 0);
        check("rst_data", ptcl_data, 0);
`ifdef USB_PTCL_STATS_EN
        check("rst_err_count", err_count, 0);
`endif
        @(negedge clk);
        check("rst_no_done", ptcl_done, 0);
        rst_b    = 1'b1;
        data_exp = '0;
        errs_exp = 0;
    endtask

    initial begin
        logic       is_in;
        logic [7:0] pid;
        @(negedge clk);
        check("reset_ready", ptcl_ready, 1);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_done", {ptcl_done, ptcl_success}, 0);
        check("reset_data", ptcl_data, 0);
        rst_b = 1'b1;
        step();

        plan_all(1, 5, 0);
        run_txn(1'b0, PID_OUT, 64'd0);
        plan_all(1, 2, 0);
        run_txn(1'b1, PID_IN, 64'hDEADBEEF_01234567);
        plan_all(1, 1, 1);
        resp[0] = 2;
        resp[1] = 2;
        run_txn(1'b1, PID_IN, 64'h0BAD_F00D_CAFE_1234);
        plan_all(0, 0, 0);
        run_txn(1'b0, PID_OUT, 64'd0);
        plan_all(1, 3, 0);
        stall[0] = 10;
        run_txn(1'b0, PID_OUT, 64'd0);
        plan_all(1, TO - 1, 0);
        run_txn(1'b1, PID_IN, 64'h1111_2222_3333_4444);
        plan_all(2, TO - 1, 2);
        resp[2] = 1;
        run_txn(1'b0, 8'hA5, 64'd0);
        plan_all(0, 0, 0);
        run_txn(1'b1, PID_IN, 64'd0);

        reset_mid(1'b0);
        plan_all(1, 4, 1);
        run_txn(1'b1, PID_IN, 64'h5555_AAAA_0F0F_F0F0);
        reset_mid(1'b1);
        run_txn(1'b0, PID_OUT, 64'd0);

        for (int k = 0; k < 40; k++) begin
            is_in = 1'($urandom);
            pid   = 8'($urandom);
            if (pid == PID_IN) pid = PID_OUT;
            if (is_in) pid = PID_IN;
            for (int a = 0; a < MAXA; a++) begin
                resp[a]  = int'($urandom % 4);
                dly[a]   = int'($urandom % TO);
                stall[a] = int'($urandom % 4);
            end
            run_txn(is_in, pid, {32'($urandom), 32'($urandom)});
            repeat ($urandom % 3) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
